axi4_lite_master: RTL and testbench
===================================

# axi4_lite_master

AXI4-Lite initiator that turns single-beat local read/write commands into AXI4-Lite transactions on an `axi_lite_if` master modport. It is the initiator-side counterpart of the team's AXI4-Lite slave and lets CPU stubs, DMA control paths and testbench drivers reach slave register banks.
- Exactly one transaction is in flight at any time.
- Each completed transaction returns one response to the local side.

## Interface
Parameters:
- DATA_WIDTH, 32, data width in bits; multiple of 8.
- ADDRESS_WIDTH, 32, address width in bits.
- WDOG_CYCLES, 1024, timeout threshold in cycles; used only when the watchdog is compiled in.

Ports:
- ACLK  in  1  clock; the only clock.
- ARESET  in  1  synchronous, active-high reset; the interface's own ACLK/ARESETn signals are not used by this block.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command can be accepted.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDRESS_WIDTH  byte address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_wstrb  in  DATA_WIDTH/8  write byte strobes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_write  out  1  response belongs to a write.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP of the transaction.
- wdog_err  out  1  sticky timeout flag; tied 0 when the watchdog is not compiled in.
- axi  modport  axi_lite_if.master  AW, W, B, AR and R channels.

## Operation
State machine states: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RSP.

- **IDLE**
  - cmd_ready = 1.
  - On cmd_valid && cmd_ready, the block registers addr, wdata and wstrb, records cmd_write, and moves to WR or RD_ADDR.
- **WR**
  - AWVALID and WVALID are both asserted on entry.
  - Each valid deasserts independently on its own handshake.
  - AWADDR, WDATA and WSTRB stay stable while their valid is high.
  - Move to WR_RESP once both handshakes are done; they may occur in the same cycle or in either order.
- **WR_RESP**
  - BREADY = 1.
  - On the B handshake, capture BRESP, set rsp_write = 1 and rsp_rdata = 0, then go to RSP.
- **RD_ADDR**
  - ARVALID = 1 and ARADDR stays stable until the AR handshake, then go to RD_DATA.
- **RD_DATA**
  - RREADY = 1.
  - On the R handshake, capture RDATA and RRESP, set rsp_write = 0, then go to RSP.
- **RSP**
  - rsp_valid = 1, with rsp_* held stable.
  - On rsp_ready, go to IDLE.
- Valid outputs never depend combinationally on the corresponding ready inputs; all AXI outputs are registered.
- SLVERR and DECERR responses are passed through unchanged. The block never retries a transaction.

## Timing
- **Reset values** (applied on every ACLK edge with ARESET = 1):
  - state = IDLE.
  - cmd_ready = 0, rsp_valid = 0.
  - AWVALID, WVALID, ARVALID, BREADY and RREADY = 0.
  - AWADDR, ARADDR, WDATA and WSTRB = 0.
  - rsp_* = 0, wdog_err = 0.
- cmd_ready first rises in the first cycle after ARESET deasserts.
- **Command-to-bus latency:** the command is accepted at edge N; AWVALID/WVALID or ARVALID is high from cycle N+1.
- **Best-case turnaround:** with slave readies already high, read acceptance to rsp_valid takes 3 cycles when RVALID returns in the cycle after the AR handshake.
- **Response-to-command latency:** rsp_ready at edge M returns cmd_ready = 1 in cycle M+1. There is no back-to-back overlap between transactions.
- **Reset mid-transaction:** the transaction is abandoned immediately and every output returns to its reset value at that edge. The slave must be reset together with this block.
- cmd_valid is ignored in every state other than IDLE. Callers must hold the command until it is accepted.
- **BVALID/RVALID arriving early:** a BVALID seen before both the AW and W handshakes are done, or an RVALID seen before the AR handshake, is not accepted, because BREADY/RREADY are still 0.

## Configuration
- `AXI_LITE_MASTER_WDOG_EN` defined: a cycle counter runs in WR, WR_RESP, RD_ADDR and RD_DATA.
  - The counter clears on every state change.
  - When it reaches WDOG_CYCLES, wdog_err is set; it is sticky until ARESET.
  - The transaction is not abandoned and the state machine is unaffected.
- `AXI_LITE_MASTER_WDOG_EN` not defined: no counter logic is generated and wdog_err is tied to 0.

## Structure
- **Shared package `axi_lite_pkg`:**
  - resp_e enum: OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11.
  - master_state_e enum (the six states above).
  - Any shared default widths.
- **Sub-module `axi_lite_wdog`:** the counter plus sticky flag, instantiated only under the macro.

## Test plan
- **Write, all readies high:** cmd write addr 0x10, data 0xDEADBEEF, wstrb 0xF → one AW and W handshake each; BRESP OKAY gives rsp_valid with rsp_write = 1 and rsp_resp = 0.
- **Read with delay:** read 0x10 with ARREADY delayed 3 cycles and RVALID delayed 5 cycles → ARADDR stable throughout; rsp_rdata = 0xDEADBEEF and rsp_resp = 0.
- **Skewed AW/W handshakes:** AWREADY at cycle 2 and WREADY at cycle 6 → AWVALID drops after cycle 2, WVALID stays high until cycle 6, BREADY rises only after both handshakes.
- **Error and backpressure:** slave returns SLVERR on a read, with rsp_ready held 0 for 4 cycles → rsp_resp = 2'b10 held stable and cmd_ready = 0 until rsp_ready.
- **Reset mid-write:** assert ARESET while WVALID = 1 → all outputs at reset values on the next edge; cmd_ready = 1 one cycle after ARESET deasserts.
- **Watchdog (macro defined, WDOG_CYCLES = 8):** BVALID never asserted → wdog_err = 1 after 8 cycles in WR_RESP; a later BVALID still completes the write normally.

Source files
------------

// File: rtl/axi_lite_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_pkg
// Description : Shared AXI4-Lite types: response codes, master FSM states and
//               default bus widths.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_lite_pkg;

    localparam int unsigned c_DEFAULT_DATA_WIDTH = 32;
    localparam int unsigned c_DEFAULT_ADDR_WIDTH = 32;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        WR_RESP = 3'd2,
        RD_ADDR = 3'd3,
        RD_DATA = 3'd4,
        RSP     = 3'd5
    } master_state_e;

    // States in which a bus transaction is outstanding.
    function automatic logic is_busy(input master_state_e s);
        return (s == WR) || (s == WR_RESP) || (s == RD_ADDR) || (s == RD_DATA);
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_lite_if.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_if
// Description : AXI4-Lite bus bundle (AW, W, B, AR, R) with master and slave
//               modports.
// Revision    : 1.0 - initial release
// ============================================================================
interface axi_lite_if #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 32
) (
    input  logic ACLK,
    input  logic ARESETn
);

    logic [ADDRESS_WIDTH-1:0]  awaddr;
    logic [2:0]                awprot;
    logic                      awvalid;
    logic                      awready;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH/8-1:0]   wstrb;
    logic                      wvalid;
    logic                      wready;
    logic [1:0]                bresp;
    logic                      bvalid;
    logic                      bready;
    logic [ADDRESS_WIDTH-1:0]  araddr;
    logic [2:0]                arprot;
    logic                      arvalid;
    logic                      arready;
    logic [DATA_WIDTH-1:0]     rdata;
    logic [1:0]                rresp;
    logic                      rvalid;
    logic                      rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  ACLK, ARESETn,
               awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface
`default_nettype wire

// File: rtl/axi_lite_wdog.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_wdog
// Description : Per-state cycle counter with a sticky timeout flag.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_wdog #(
    parameter int unsigned WDOG_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic restart,
    output logic err
);

    localparam int unsigned c_CNT_W = $clog2(WDOG_CYCLES + 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_err;

    // Counter saturates at the threshold so a long stall cannot wrap it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (restart || !active) begin
                r_cnt <= '0;
            end else if (r_cnt != c_CNT_W'(WDOG_CYCLES)) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (active && !restart && (r_cnt == c_CNT_W'(WDOG_CYCLES - 1))) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err = r_err;

endmodule
`default_nettype wire

// File: rtl/axi4_lite_master.sv
`default_nettype none
// ============================================================================
// Module      : axi4_lite_master
// Description : Single-outstanding AXI4-Lite initiator driven by a local
//               command/response handshake. Optional watchdog is compiled in
//               with AXI_LITE_MASTER_WDOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module axi4_lite_master
    import axi_lite_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = c_DEFAULT_DATA_WIDTH,
    parameter int unsigned ADDRESS_WIDTH = c_DEFAULT_ADDR_WIDTH,
    parameter int unsigned WDOG_CYCLES   = 1024
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDRESS_WIDTH-1:0]  cmd_addr,
    input  logic [DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      rsp_write,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                rsp_resp,
    output logic                      wdog_err,
    axi_lite_if.master                axi
);

    master_state_e              r_state,     w_state_nxt;
    logic                       r_cmd_ready, w_cmd_ready_nxt;
    logic                       r_awvalid,   w_awvalid_nxt;
    logic                       r_wvalid,    w_wvalid_nxt;
    logic                       r_arvalid,   w_arvalid_nxt;
    logic                       r_bready,    w_bready_nxt;
    logic                       r_rready,    w_rready_nxt;
    logic [ADDRESS_WIDTH-1:0]   r_addr,      w_addr_nxt;
    logic [DATA_WIDTH-1:0]      r_wdata,     w_wdata_nxt;
    logic [DATA_WIDTH/8-1:0]    r_wstrb,     w_wstrb_nxt;
    logic                       r_rsp_valid, w_rsp_valid_nxt;
    logic                       r_rsp_write, w_rsp_write_nxt;
    logic [DATA_WIDTH-1:0]      r_rsp_rdata, w_rsp_rdata_nxt;
    logic [1:0]                 r_rsp_resp,  w_rsp_resp_nxt;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state     <= IDLE;
            r_cmd_ready <= 1'b0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_bready    <= 1'b0;
            r_rready    <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_write <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= 2'b00;
        end else begin
            r_state     <= w_state_nxt;
            r_cmd_ready <= w_cmd_ready_nxt;
            r_awvalid   <= w_awvalid_nxt;
            r_wvalid    <= w_wvalid_nxt;
            r_arvalid   <= w_arvalid_nxt;
            r_bready    <= w_bready_nxt;
            r_rready    <= w_rready_nxt;
            r_addr      <= w_addr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_wstrb     <= w_wstrb_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_write <= w_rsp_write_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_resp  <= w_rsp_resp_nxt;
        end
    end

    // Every output is computed one cycle ahead so the bus sees flop outputs only.
    always_comb begin
        w_state_nxt     = r_state;
        w_cmd_ready_nxt = r_cmd_ready;
        w_awvalid_nxt   = r_awvalid;
        w_wvalid_nxt    = r_wvalid;
        w_arvalid_nxt   = r_arvalid;
        w_bready_nxt    = r_bready;
        w_rready_nxt    = r_rready;
        w_addr_nxt      = r_addr;
        w_wdata_nxt     = r_wdata;
        w_wstrb_nxt     = r_wstrb;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_write_nxt = r_rsp_write;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_resp_nxt  = r_rsp_resp;

        case (r_state)
            IDLE: begin
                w_cmd_ready_nxt = 1'b1;
                if (cmd_valid && r_cmd_ready) begin
                    w_cmd_ready_nxt = 1'b0;
                    w_addr_nxt      = cmd_addr;
                    w_wdata_nxt     = cmd_wdata;
                    w_wstrb_nxt     = cmd_wstrb;
                    if (cmd_write) begin
                        w_state_nxt   = WR;
                        w_awvalid_nxt = 1'b1;
                        w_wvalid_nxt  = 1'b1;
                    end else begin
                        w_state_nxt   = RD_ADDR;
                        w_arvalid_nxt = 1'b1;
                    end
                end
            end
            WR: begin
                w_awvalid_nxt = r_awvalid && !axi.awready;
                w_wvalid_nxt  = r_wvalid && !axi.wready;
                if (!w_awvalid_nxt && !w_wvalid_nxt) begin
                    w_state_nxt  = WR_RESP;
                    w_bready_nxt = 1'b1;
                end
            end
            WR_RESP: begin
                if (axi.bvalid) begin
                    w_bready_nxt    = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_write_nxt = 1'b1;
                    w_rsp_rdata_nxt = '0;
                    w_rsp_resp_nxt  = axi.bresp;
                    w_state_nxt     = RSP;
                end
            end
            RD_ADDR: begin
                if (axi.arready) begin
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b1;
                    w_state_nxt   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (axi.rvalid) begin
                    w_rready_nxt    = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_write_nxt = 1'b0;
                    w_rsp_rdata_nxt = axi.rdata;
                    w_rsp_resp_nxt  = axi.rresp;
                    w_state_nxt     = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_cmd_ready_nxt = 1'b1;
                    w_state_nxt     = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign cmd_ready   = r_cmd_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_write   = r_rsp_write;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_resp    = r_rsp_resp;

    assign axi.awaddr  = r_addr;
    assign axi.awprot  = 3'b000;
    assign axi.awvalid = r_awvalid;
    assign axi.wdata   = r_wdata;
    assign axi.wstrb   = r_wstrb;
    assign axi.wvalid  = r_wvalid;
    assign axi.bready  = r_bready;
    assign axi.araddr  = r_addr;
    assign axi.arprot  = 3'b000;
    assign axi.arvalid = r_arvalid;
    assign axi.rready  = r_rready;

`ifdef AXI_LITE_MASTER_WDOG_EN
    logic w_busy;
    logic w_state_change;

    assign w_busy         = is_busy(r_state);
    assign w_state_change = (w_state_nxt != r_state);

    axi_lite_wdog #(
        .WDOG_CYCLES (WDOG_CYCLES)
    ) u_wdog (
        .clk     (ACLK),
        .rst     (ARESET),
        .active  (w_busy),
        .restart (w_state_change),
        .err     (wdog_err)
    );
`else
    assign wdog_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi4_lite_master
// Description : Scoreboard bench for axi4_lite_master with a delay-programmable
//               AXI4-Lite slave model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi4_lite_master;
    import axi_lite_pkg::*;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        wdog_err;

    always #5 ACLK = ~ACLK;

    axi_lite_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32)) axi (.ACLK(ACLK), .ARESETn(~ARESET));

    axi4_lite_master #(
        .DATA_WIDTH    (32),
        .ADDRESS_WIDTH (32),
        .WDOG_CYCLES   (8)
    ) dut (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_wstrb (cmd_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_write (rsp_write),
        .rsp_rdata (rsp_rdata),
        .rsp_resp  (rsp_resp),
        .wdog_err  (wdog_err),
        .axi       (axi)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- slave model ----------------
    int unsigned aw_dly, w_dly, ar_dly, r_dly, b_dly;
    logic [1:0]  b_rsp_cfg, r_rsp_cfg;
    int unsigned aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    logic        aw_got, w_got, b_pend, r_pend;
    logic [31:0] s_awaddr, s_wdata, s_araddr;
    logic [3:0]  s_wstrb;
    logic [31:0] mem [16];

    assign axi.awready = axi.awvalid && !aw_got && (aw_cnt >= aw_dly);
    assign axi.wready  = axi.wvalid && !w_got && (w_cnt >= w_dly);
    assign axi.bvalid  = b_pend && (b_cnt >= b_dly);
    assign axi.bresp   = b_rsp_cfg;
    assign axi.arready = axi.arvalid && !r_pend && (ar_cnt >= ar_dly);
    assign axi.rvalid  = r_pend && (r_cnt >= r_dly);
    assign axi.rdata   = mem[s_araddr[5:2]];
    assign axi.rresp   = r_rsp_cfg;

    always @(posedge ACLK) begin
        if (ARESET) begin
            aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
            s_awaddr <= '0; s_wdata <= '0; s_wstrb <= '0; s_araddr <= '0;
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else begin
            if (axi.awvalid && axi.awready) begin
                aw_got <= 1'b1; aw_cnt <= 0; s_awaddr <= axi.awaddr;
            end else if (axi.awvalid && !aw_got) begin
                aw_cnt <= aw_cnt + 1;
            end
            if (axi.wvalid && axi.wready) begin
                w_got <= 1'b1; w_cnt <= 0; s_wdata <= axi.wdata; s_wstrb <= axi.wstrb;
            end else if (axi.wvalid && !w_got) begin
                w_cnt <= w_cnt + 1;
            end
            if (aw_got && w_got) begin
                for (int i = 0; i < 4; i++)
                    if (s_wstrb[i]) mem[s_awaddr[5:2]][8*i +: 8] <= s_wdata[8*i +: 8];
                aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b1; b_cnt <= 0;
            end
            if (b_pend) begin
                if (axi.bvalid && axi.bready) b_pend <= 1'b0;
                else if (!axi.bvalid)         b_cnt <= b_cnt + 1;
            end
            if (axi.arvalid && axi.arready) begin
                r_pend <= 1'b1; r_cnt <= 0; ar_cnt <= 0; s_araddr <= axi.araddr;
            end else if (axi.arvalid) begin
                ar_cnt <= ar_cnt + 1;
            end
            if (r_pend) begin
                if (axi.rvalid && axi.rready) r_pend <= 1'b0;
                else if (!axi.rvalid)         r_cnt <= r_cnt + 1;
            end
        end
    end

    // ---------------- bus payload monitor ----------------
    logic [31:0] cur_addr, cur_wdata;
    logic [3:0]  cur_wstrb;

    always @(negedge ACLK) begin
        if (ARESET === 1'b0) begin
            if (axi.awvalid) check_eq("awaddr_stable", axi.awaddr, cur_addr);
            if (axi.wvalid) begin
                check_eq("wdata_stable", axi.wdata, cur_wdata);
                check_eq("wstrb_stable", axi.wstrb, cur_wstrb);
            end
            if (axi.arvalid) check_eq("araddr_stable", axi.araddr, cur_addr);
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic        write;
        logic [31:0] rdata;
        logic [1:0]  resp;
    } exp_t;
    exp_t sb[$];

    task automatic send_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [1:0] resp, input logic [31:0] rd);
        exp_t e;
        int   n = 0;
        e.write = wr;
        e.rdata = wr ? 32'h0 : rd;
        e.resp  = resp;
        sb.push_back(e);
        cur_addr = a; cur_wdata = d; cur_wstrb = s;
        cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 50) begin
            @(posedge ACLK); #1; n++;
        end
        check_eq("cmd_accept_in_time", 64'(n < 50), 1);
        @(posedge ACLK); #1;
        cmd_valid = 1'b0;
        if (wr) check_eq("wr_bus_valid", {axi.awvalid, axi.wvalid, axi.arvalid}, 3'b110);
        else    check_eq("rd_bus_valid", {axi.awvalid, axi.wvalid, axi.arvalid}, 3'b001);
    endtask

    task automatic recv_rsp(input int hold, output int lat);
        exp_t e;
        int   n = 0;
        lat = 1;
        while (!rsp_valid && n < 200) begin
            @(posedge ACLK); #1; n++; lat++;
        end
        check_eq("rsp_in_time", rsp_valid, 1);
        if (sb.size() == 0) begin
            check_eq("sb_nonempty", 0, 1);
            return;
        end
        e = sb.pop_front();
        for (int i = 0; i < hold; i++) begin
            check_eq("hold_valid", rsp_valid, 1);
            check_eq("hold_resp", rsp_resp, e.resp);
            check_eq("hold_rdata", rsp_rdata, e.rdata);
            check_eq("hold_cmd_ready", cmd_ready, 0);
            @(posedge ACLK); #1;
        end
        check_eq("rsp_write", rsp_write, e.write);
        check_eq("rsp_rdata", rsp_rdata, e.rdata);
        check_eq("rsp_resp", rsp_resp, e.resp);
        rsp_ready = 1'b1;
        @(posedge ACLK); #1;
        rsp_ready = 1'b0;
        check_eq("rsp_to_cmd_ready", {cmd_ready, rsp_valid}, 2'b10);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_valids"}, {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}, 5'b0);
        check_eq({tag, "_cmd_rsp"}, {cmd_ready, rsp_valid, rsp_write, rsp_resp}, 5'b0);
        check_eq({tag, "_aw_w"}, {axi.awaddr, axi.wdata}, 64'h0);
        check_eq({tag, "_ar_strb"}, {axi.araddr, axi.wstrb}, 36'h0);
        check_eq({tag, "_rdata_wdog"}, {rsp_rdata, wdog_err}, 33'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int lat;
        ARESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
        aw_dly = 0; w_dly = 0; ar_dly = 0; r_dly = 0; b_dly = 0;
        b_rsp_cfg = OKAY; r_rsp_cfg = OKAY;
        cur_addr = '0; cur_wdata = '0; cur_wstrb = '0;

        repeat (3) @(posedge ACLK);
        #1;
        check_reset_outputs("reset");
        ARESET = 1'b0;
        @(posedge ACLK); #1;
        check_eq("cmd_ready_first_cycle", cmd_ready, 1);

        // Write, all readies high
        send_cmd(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, OKAY, 32'h0);
        recv_rsp(0, lat);
        check_eq("best_write_latency", lat, 4);

        // Read with delayed AR and R
        ar_dly = 3; r_dly = 5;
        send_cmd(1'b0, 32'h10, 32'h0, 4'h0, OKAY, 32'hDEADBEEF);
        recv_rsp(0, lat);
        ar_dly = 0; r_dly = 0;

        // Skewed AW/W handshakes
        aw_dly = 1; w_dly = 5;
        send_cmd(1'b1, 32'h20, 32'h12345678, 4'h5, OKAY, 32'h0);
        for (int c = 1; c <= 7; c++) begin
            check_eq("skew_awvalid", axi.awvalid, 64'(c <= 2));
            check_eq("skew_wvalid", axi.wvalid, 64'(c <= 6));
            check_eq("skew_bready", axi.bready, 64'(c == 7));
            if (c < 7) begin
                @(posedge ACLK); #1;
            end
        end
        recv_rsp(0, lat);
        aw_dly = 0; w_dly = 0;

        // SLVERR read held under response backpressure; partial-strobe data
        r_rsp_cfg = SLVERR;
        send_cmd(1'b0, 32'h20, 32'h0, 4'h0, SLVERR, 32'h00340078);
        recv_rsp(4, lat);
        r_rsp_cfg = OKAY;

        // DECERR write passes through
        b_rsp_cfg = DECERR;
        send_cmd(1'b1, 32'h24, 32'h0BADF00D, 4'hF, DECERR, 32'h0);
        recv_rsp(2, lat);
        b_rsp_cfg = OKAY;

        // Reset in the middle of a write
        w_dly = 100;
        send_cmd(1'b1, 32'h40, 32'hCAFEF00D, 4'hF, OKAY, 32'h0);
        @(posedge ACLK); #1;
        check_eq("pre_reset_wvalid", axi.wvalid, 1);
        ARESET = 1'b1;
        @(posedge ACLK); #1;
        check_reset_outputs("midwr_reset");
        sb.delete();
        ARESET = 1'b0;
        w_dly = 0;
        @(posedge ACLK); #1;
        check_eq("cmd_ready_after_reset", cmd_ready, 1);

        // Best-case write then read after reset
        send_cmd(1'b1, 32'h30, 32'hA5A55A5A, 4'hF, OKAY, 32'h0);
        recv_rsp(0, lat);
        check_eq("best_write_latency2", lat, 4);
        send_cmd(1'b0, 32'h30, 32'h0, 4'h0, OKAY, 32'hA5A55A5A);
        recv_rsp(0, lat);
        check_eq("best_read_latency", lat, 3);

`ifdef AXI_LITE_MASTER_WDOG_EN
        // B response withheld long enough to trip the watchdog
        b_dly = 20;
        send_cmd(1'b1, 32'h08, 32'h00000001, 4'hF, OKAY, 32'h0);
        repeat (8) begin
            @(posedge ACLK); #1;
        end
        check_eq("wdog_before_limit", wdog_err, 0);
        @(posedge ACLK); #1;
        check_eq("wdog_at_limit", wdog_err, 1);
        recv_rsp(0, lat);
        check_eq("wdog_sticky", wdog_err, 1);
        b_dly = 0;
`else
        check_eq("wdog_tied_low", wdog_err, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
